alu_cmd_master: RTL and testbench

Hardware initiator for the ALU command interface. Accepts operation requests on a valid/ready port, drives the ALU enable/opcode/operand pins, and captures `alu_out`. Services `alu_irq` by pulsing `alu_irq_clr`, then returns result plus status on a valid/ready response port. Sits between a host/sequencer and the `alu` block, replacing the testbench driver in system-level builds.

---
 rtl/alu_cmd_master.sv | 219 +++++++++++++++++++++
 tb/tb_alu_cmd_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// alu_cmd_master
// Initiator for the ALU command interface. Takes one operation request at a
// time, drives the ALU enables/opcodes/operands for one cycle, waits
// RESULT_LAT cycles and captures alu_out/alu_irq. A raised irq is serviced
// with a single alu_irq_clr pulse before the result is returned.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, holds its payload stable until that edge;
// ready may be high without valid. req_ready is only high in IDLE and
// rsp_valid only in RESP, so at most one operation is ever outstanding.
//
// Ports
//   alu_clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_mode, req_op           0: A-group op[2:0], 1: B-group op[1:0]
//   req_a, req_b               operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_irq, rsp_err captured result, irq seen, irq clear timeout
//   alu_enable*, alu_op_*      ALU control pins
//   alu_in_a, alu_in_b         ALU operand pins (latched request operands)
//   alu_out, alu_irq           ALU result and interrupt
//   alu_irq_clr                one-cycle interrupt clear pulse
//   op_count, irq_count        completed ops / irqs serviced, wrap mod 2^16
//   dbg_state                  current FSM state encoding
module alu_cmd_master #(
  parameter int DW          = 8,
  parameter int RESULT_LAT  = 1,
  parameter int IRQ_TIMEOUT = 4
) (
  input  logic          alu_clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_mode,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_irq,
  output logic          rsp_err,
  output logic          alu_enable,
  output logic          alu_enable_a,
  output logic          alu_enable_b,
  output logic [2:0]    alu_op_a,
  output logic [1:0]    alu_op_b,
  output logic [DW-1:0] alu_in_a,
  output logic [DW-1:0] alu_in_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_irq,
  output logic          alu_irq_clr,
  output logic [15:0]   op_count,
  output logic [15:0]   irq_count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRIVE    = 3'd1,
    S_WAIT     = 3'd2,
    S_IRQ_CLR  = 3'd3,
    S_IRQ_WAIT = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  localparam logic [15:0] LAT_LAST = 16'(RESULT_LAT - 1);
  localparam logic [15:0] TO_LAST  = 16'(IRQ_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_irq_q, rsp_irq_d, rsp_err_q, rsp_err_d;
  logic [15:0]   op_count_q, op_count_d, irq_count_q, irq_count_d;
  logic          req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic          en_q, en_d, en_a_q, en_a_d, en_b_q, en_b_d;
  logic [2:0]    op_a_q, op_a_d;
  logic [1:0]    op_b_q, op_b_d;
  logic          irq_clr_q, irq_clr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    op_d        = op_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_irq_d   = rsp_irq_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    irq_count_d = irq_count_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          mode_d    = req_mode;
          op_d      = req_op;
          in_a_d    = req_a;
          in_b_d    = req_b;
          rsp_irq_d = 1'b0;
          rsp_err_d = 1'b0;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rsp_data_d = alu_out;
          rsp_irq_d  = alu_irq;
          state_d    = alu_irq ? S_IRQ_CLR : S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IRQ_CLR: begin
        irq_count_d = irq_count_q + 16'd1;
        cnt_d       = '0;
        state_d     = S_IRQ_WAIT;
      end
      S_IRQ_WAIT: begin
        // cnt_q counts high samples already seen; no second clear pulse.
        if (!alu_irq) begin
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    en_d        = (state_d == S_DRIVE);
    en_a_d      = en_d && !mode_d;
    en_b_d      = en_d && mode_d;
    op_a_d      = en_a_d ? op_d : 3'd0;
    op_b_d      = en_b_d ? op_d[1:0] : 2'd0;
    irq_clr_d   = (state_d == S_IRQ_CLR);
  end

  always_ff @(posedge alu_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      op_q        <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_irq_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
      irq_count_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      en_q        <= 1'b0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      irq_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      op_q        <= op_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_irq_q   <= rsp_irq_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
      irq_count_q <= irq_count_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      en_q        <= en_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      irq_clr_q   <= irq_clr_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;
  assign rsp_err      = rsp_err_q;
  assign alu_enable   = en_q;
  assign alu_enable_a = en_a_q;
  assign alu_enable_b = en_b_q;
  assign alu_op_a     = op_a_q;
  assign alu_op_b     = op_b_q;
  assign alu_in_a     = in_a_q;
  assign alu_in_b     = in_b_q;
  assign alu_irq_clr  = irq_clr_q;
  assign op_count     = op_count_q;
  assign irq_count    = irq_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Testbench for alu_cmd_master (DW=8, RESULT_LAT=1, IRQ_TIMEOUT=4).
// A small ALU stub returns a+b (or 8'hFF when raising irq) one edge after
// alu_enable; its irq either stays low, drops at the edge that sees the
// clear pulse, or stays high until the bench kills it.
module tb_alu_cmd_master;

  logic       alu_clk = 1'b0;
  logic       rst;
  logic       req_valid, req_mode, rsp_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_ready, rsp_valid, rsp_irq, rsp_err;
  logic [7:0] rsp_data, alu_in_a, alu_in_b;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [2:0] alu_op_a, dbg_state;
  logic [1:0] alu_op_b;
  logic [15:0] op_count, irq_count;
  logic [7:0] alu_out = 8'h00;
  logic       alu_irq = 1'b0;

  int stub_irq_mode = 0;  // 0 none, 1 drop after clear, 2 stuck high
  logic stub_kill = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ops = 0;
  int exp_irqs = 0;

  alu_cmd_master #(.DW(8), .RESULT_LAT(1), .IRQ_TIMEOUT(4)) dut (
    .alu_clk(alu_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_irq(rsp_irq), .rsp_err(rsp_err),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_irq(alu_irq), .alu_irq_clr(alu_irq_clr),
    .op_count(op_count), .irq_count(irq_count), .dbg_state(dbg_state)
  );

  // clock
  always #5 alu_clk = ~alu_clk;

  // ALU stub
  always @(posedge alu_clk) begin
    if (stub_kill) begin
      alu_irq <= 1'b0;
    end else if (alu_enable) begin
      alu_out <= (stub_irq_mode != 0) ? 8'hFF : alu_in_a + alu_in_b;
      if (stub_irq_mode != 0) alu_irq <= 1'b1;
    end else if (alu_irq_clr && stub_irq_mode == 1) begin
      alu_irq <= 1'b0;
    end
  end

  typedef struct {
    logic       mode;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         irq_mode;
    logic [7:0] exp_data;
    logic       exp_irq;
    logic       exp_err;
    logic       exp_en_a;
    logic       exp_en_b;
    logic [2:0] exp_op_a;
    logic [1:0] exp_op_b;
    int         exp_lat;   // negedges after the accept edge's DRIVE sample
    int         exp_clr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, follow it through, hold rsp_ready low for 'hold'
  // extra cycles after rsp_valid, then complete the handshake.
  task automatic do_op(input vec_t v, input int hold);
    int k;
    int en_cnt;
    int clr_cnt;
    int lat;
    bit seen;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge alu_clk);
      k++;
    end
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    stub_irq_mode = v.irq_mode;
    req_mode  = v.mode;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge alu_clk);
    @(negedge alu_clk);
    req_valid = 1'b0;
    req_a     = 8'h5A;  // changes after accept must not matter
    k = 0; en_cnt = 0; clr_cnt = 0; seen = 1'b0; lat = -1;
    while (!seen && k < 40) begin
      if (alu_enable) en_cnt++;
      if (alu_irq_clr) clr_cnt++;
      if (k == 0) begin
        check("drive_enable", {31'd0, alu_enable}, 32'd1);
        check("drive_en_a", {31'd0, alu_enable_a}, {31'd0, v.exp_en_a});
        check("drive_en_b", {31'd0, alu_enable_b}, {31'd0, v.exp_en_b});
        check("drive_op_a", {29'd0, alu_op_a}, {29'd0, v.exp_op_a});
        check("drive_op_b", {30'd0, alu_op_b}, {30'd0, v.exp_op_b});
        check("drive_in_a", {24'd0, alu_in_a}, {24'd0, v.a});
        check("drive_in_b", {24'd0, alu_in_b}, {24'd0, v.b});
      end
      if (k == 1) begin
        check("wait_op_a_zero", {29'd0, alu_op_a}, 32'd0);
        check("wait_in_a_held", {24'd0, alu_in_a}, {24'd0, v.a});
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        @(negedge alu_clk);
        k++;
      end
    end
    check("rsp_latency", lat, v.exp_lat);
    check("enable_cycles", en_cnt, 32'd1);
    check("irq_clr_pulses", clr_cnt, v.exp_clr);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, v.exp_data});
    check("rsp_irq", {31'd0, rsp_irq}, {31'd0, v.exp_irq});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    if (v.irq_mode != 0) exp_irqs++;
    check("irq_count", {16'd0, irq_count}, exp_irqs);
    for (int i = 0; i < hold; i++) begin
      @(negedge alu_clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_stable", {22'd0, rsp_err, rsp_irq, rsp_data},
            {22'd0, v.exp_err, v.exp_irq, v.exp_data});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge alu_clk);
    exp_ops++;
    check("op_count", {16'd0, op_count}, exp_ops);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    if (v.irq_mode == 2) begin
      stub_irq_mode = 0;
      stub_kill = 1'b1;
      @(negedge alu_clk);
      stub_kill = 1'b0;
    end
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1;
    req_valid = 1'b0; req_mode = 1'b0; req_op = 3'd0;
    req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b0;

    //          mode  op      a      b      irq data   irq   err   en_a  en_b  op_a  op_b  lat clr
    vecs[0] = '{1'b0, 3'b010, 8'h12, 8'h34, 0, 8'h46, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 2'd0, 2, 0};
    vecs[1] = '{1'b1, 3'b111, 8'h05, 8'h03, 0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3, 2, 0};
    vecs[2] = '{1'b0, 3'b111, 8'hFF, 8'h01, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 2'd0, 2, 0};
    vecs[3] = '{1'b1, 3'b010, 8'h80, 8'h80, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2, 2, 0};
    vecs[4] = '{1'b0, 3'b000, 8'h12, 8'h34, 1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 4, 1};
    vecs[5] = '{1'b1, 3'b001, 8'h10, 8'h20, 2, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 2'd1, 7, 1};
    vecs[6] = '{1'b0, 3'b101, 8'h0A, 8'h0B, 0, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 2'd0, 2, 0};

    // reset state
    repeat (3) @(negedge alu_clk);
    check("reset_outputs",
          {22'd0, req_ready, rsp_valid, rsp_irq, rsp_err, alu_enable, alu_enable_a,
           alu_enable_b, alu_irq_clr, alu_op_a == 3'd0, alu_op_b == 2'd0},
          {30'd0, 2'b11});
    check("reset_data", {rsp_data, alu_in_a, alu_in_b, 8'h00}, 32'd0);
    check("reset_counts", {op_count, irq_count}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_low_after_release", {31'd0, req_ready}, 32'd0);
    @(posedge alu_clk);
    #1;
    check("ready_first_edge", {31'd0, req_ready}, 32'd1);
    @(negedge alu_clk);

    for (int i = 0; i < 7; i++) do_op(vecs[i], 0);

    // response back-pressure: rsp_ready low for 5 cycles
    rv = '{1'b0, 3'b001, 8'h21, 8'h22, 0, 8'h43, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 2, 0};
    do_op(rv, 5);

    // reset while in WAIT
    req_mode = 1'b0; req_op = 3'd3; req_a = 8'h01; req_b = 8'h02;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge alu_clk);
    @(negedge alu_clk);
    req_valid = 1'b0;
    @(negedge alu_clk);
    check("pre_reset_state_wait", {29'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    check("midop_reset_outputs",
          {23'd0, req_ready, rsp_valid, rsp_irq, rsp_err, alu_enable, alu_enable_a,
           alu_enable_b, alu_irq_clr, dbg_state == 3'd0},
          32'd1);
    check("midop_reset_counts", {op_count, irq_count}, 32'd0);
    check("midop_reset_operands", {16'd0, alu_in_a, alu_in_b}, 32'd0);
    @(negedge alu_clk);
    rst = 1'b0;
    exp_ops = 0;
    exp_irqs = 0;
    rv = '{1'b1, 3'b110, 8'h40, 8'h02, 0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2, 2, 0};
    do_op(rv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
